// File: rtl/cpu_pkg.sv
// Shared definitions for the issue scoreboard and writeback arbiter:
// instruction field positions, default widths and the grant encoding.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 16;
  localparam int INST_W = 16;

  localparam int RS1_MSB = 11;
  localparam int RS1_LSB = 8;
  localparam int RS2_MSB = 7;
  localparam int RS2_LSB = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 0;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LD  = 1'b1
  } gnt_e;

  function automatic logic [RS1_MSB-RS1_LSB:0] f_rs1(input logic [INST_W-1:0] inst);
    return inst[RS1_MSB:RS1_LSB];
  endfunction

  function automatic logic [RS2_MSB-RS2_LSB:0] f_rs2(input logic [INST_W-1:0] inst);
    return inst[RS2_MSB:RS2_LSB];
  endfunction

  function automatic logic [RD_MSB-RD_LSB:0] f_rd(input logic [INST_W-1:0] inst);
    return inst[RD_MSB:RD_LSB];
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter for the register-file write port. A lone
// requester always wins; on contention the source not granted last wins.
module wb_rr_arbiter
  import cpu_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_alu_valid,
  input  logic i_ld_valid,
  output logic o_alu_gnt,
  output logic o_ld_gnt,
  output gnt_e o_sel
);

  gnt_e r_last_grant;
  logic w_alu_gnt;
  logic w_ld_gnt;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_alu_gnt = 1'b0;
    w_ld_gnt  = 1'b0;
    if (i_alu_valid && i_ld_valid) begin
      if (r_last_grant == GNT_LD) w_alu_gnt = 1'b1;
      else                        w_ld_gnt  = 1'b1;
    end else begin
      w_alu_gnt = i_alu_valid;
      w_ld_gnt  = i_ld_valid;
    end
  end

  assign o_alu_gnt = w_alu_gnt;
  assign o_ld_gnt  = w_ld_gnt;
  assign o_sel     = w_ld_gnt ? GNT_LD : GNT_ALU;

  // NOTE: sequential state is updated with non-blocking assignments so all
  // flops sample their inputs from the same pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_last_grant <= GNT_LD;
    end else if (w_alu_gnt || w_ld_gnt) begin
      r_last_grant <= o_sel;
    end
  end

endmodule

// File: rtl/reg_scoreboard_wb_arbiter.sv
// Issue scoreboard with RAW/WAW/in-flight stalls, plus a registered commit
// stage that drives the register-file write port from the arbitrated winner.
module reg_scoreboard_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W       = cpu_pkg::DATA_W,
  parameter int NREG         = cpu_pkg::NREG,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_issue_valid,
  input  logic [INST_W-1:0]       i_issue_inst,
  input  logic                    i_issue_uses_rs2,
  input  logic                    i_issue_writes_rd,
  input  logic                    i_flush,
  output logic                    o_issue_ready,
  input  logic                    i_alu_wb_valid,
  input  logic [$clog2(NREG)-1:0] i_alu_wb_addr,
  input  logic [DATA_W-1:0]       i_alu_wb_data,
  output logic                    o_alu_wb_ready,
  input  logic                    i_ld_wb_valid,
  input  logic [$clog2(NREG)-1:0] i_ld_wb_addr,
  input  logic [DATA_W-1:0]       i_ld_wb_data,
  output logic                    o_ld_wb_ready,
  output logic                    o_rf_write_en,
  output logic [$clog2(NREG)-1:0] o_rf_write_add,
  output logic [DATA_W-1:0]       o_rf_write_data,
  output logic [NREG-1:0]         o_pending,
  output logic                    o_wb_err
);

  localparam int AW    = $clog2(NREG);
  localparam int CNT_W = 4;

  logic [NREG-1:0]   r_pending;
  logic [CNT_W-1:0]  r_inflight;
  logic              r_rf_write_en;
  logic [AW-1:0]     r_rf_write_add;
  logic [DATA_W-1:0] r_rf_write_data;
  logic              r_wb_err;

  logic [AW-1:0]     w_rs1;
  logic [AW-1:0]     w_rs2;
  logic [AW-1:0]     w_rd;
  logic              w_at_limit;
  logic              w_hazard;
  logic              w_issue_ready;
  logic              w_issue_set;
  logic              w_commit_dec;
  logic              w_alu_gnt;
  logic              w_ld_gnt;
  logic              w_gnt_any;
  gnt_e              w_sel;
  logic [AW-1:0]     w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_data;
  logic [NREG-1:0]   w_pending_nxt;
  logic [CNT_W-1:0]  w_inflight_nxt;
  logic              w_unused_opcode;

  assign w_rs1 = AW'(f_rs1(i_issue_inst));
  assign w_rs2 = AW'(f_rs2(i_issue_inst));
  assign w_rd  = AW'(f_rd(i_issue_inst));
  assign w_unused_opcode = &{1'b0, i_issue_inst[INST_W-1:RS1_MSB+1]};

  assign w_at_limit = (r_inflight == CNT_W'(MAX_INFLIGHT));
  assign w_hazard   = r_pending[w_rs1]
                    | (i_issue_uses_rs2  & r_pending[w_rs2])
                    | (i_issue_writes_rd & r_pending[w_rd])
                    | (i_issue_writes_rd & w_at_limit);

  assign w_issue_ready = ~w_hazard & ~i_flush;
  assign w_issue_set   = i_issue_valid & w_issue_ready & i_issue_writes_rd;
  // A commit to a register nobody issued must not wrap the counter.
  assign w_commit_dec  = r_rf_write_en & (r_inflight != '0);

  wb_rr_arbiter u_arb (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_alu_valid (i_alu_wb_valid),
    .i_ld_valid  (i_ld_wb_valid),
    .o_alu_gnt   (w_alu_gnt),
    .o_ld_gnt    (w_ld_gnt),
    .o_sel       (w_sel)
  );

  assign w_gnt_any  = w_alu_gnt | w_ld_gnt;
  assign w_gnt_addr = (w_sel == GNT_LD) ? i_ld_wb_addr : i_alu_wb_addr;
  assign w_gnt_data = (w_sel == GNT_LD) ? i_ld_wb_data : i_alu_wb_data;

  // Clear first, then set, so a forced same-register collision leaves it pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_rf_write_en) w_pending_nxt[r_rf_write_add] = 1'b0;
    if (w_issue_set)   w_pending_nxt[w_rd]           = 1'b1;
  end

  always_comb begin
    w_inflight_nxt = r_inflight;
    case ({w_issue_set, w_commit_dec})
      2'b10:   w_inflight_nxt = r_inflight + CNT_W'(1);
      2'b01:   w_inflight_nxt = r_inflight - CNT_W'(1);
      default: w_inflight_nxt = r_inflight;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pending       <= '0;
      r_inflight      <= '0;
      r_rf_write_en   <= 1'b0;
      r_rf_write_add  <= '0;
      r_rf_write_data <= '0;
      r_wb_err        <= 1'b0;
    end else begin
      r_pending     <= w_pending_nxt;
      r_inflight    <= w_inflight_nxt;
      r_rf_write_en <= w_gnt_any;
      if (w_gnt_any) begin
        r_rf_write_add  <= w_gnt_addr;
        r_rf_write_data <= w_gnt_data;
        if (!r_pending[w_gnt_addr]) r_wb_err <= 1'b1;
      end
    end
  end

  assign o_issue_ready   = w_issue_ready;
  assign o_alu_wb_ready  = w_alu_gnt;
  assign o_ld_wb_ready   = w_ld_gnt;
  assign o_rf_write_en   = r_rf_write_en;
  assign o_rf_write_add  = r_rf_write_add;
  assign o_rf_write_data = r_rf_write_data;
  assign o_pending       = r_pending;
  assign o_wb_err        = r_wb_err;

endmodule

// File: tb/tb_reg_scoreboard_wb_arbiter.sv
// Directed bench for reg_scoreboard_wb_arbiter: inputs change on the falling
// edge, outputs are compared 1ns later against hand-derived values.
module tb_reg_scoreboard_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_issue_valid = 1'b0;
  logic [15:0] i_issue_inst = '0;
  logic        i_issue_uses_rs2 = 1'b0;
  logic        i_issue_writes_rd = 1'b0;
  logic        i_flush = 1'b0;
  logic        o_issue_ready;
  logic        i_alu_wb_valid = 1'b0;
  logic [3:0]  i_alu_wb_addr = '0;
  logic [15:0] i_alu_wb_data = '0;
  logic        o_alu_wb_ready;
  logic        i_ld_wb_valid = 1'b0;
  logic [3:0]  i_ld_wb_addr = '0;
  logic [15:0] i_ld_wb_data = '0;
  logic        o_ld_wb_ready;
  logic        o_rf_write_en;
  logic [3:0]  o_rf_write_add;
  logic [15:0] o_rf_write_data;
  logic [15:0] o_pending;
  logic        o_wb_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  reg_scoreboard_wb_arbiter #(.DATA_W(16), .NREG(16), .MAX_INFLIGHT(4)) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_issue_valid     (i_issue_valid),
    .i_issue_inst      (i_issue_inst),
    .i_issue_uses_rs2  (i_issue_uses_rs2),
    .i_issue_writes_rd (i_issue_writes_rd),
    .i_flush           (i_flush),
    .o_issue_ready     (o_issue_ready),
    .i_alu_wb_valid    (i_alu_wb_valid),
    .i_alu_wb_addr     (i_alu_wb_addr),
    .i_alu_wb_data     (i_alu_wb_data),
    .o_alu_wb_ready    (o_alu_wb_ready),
    .i_ld_wb_valid     (i_ld_wb_valid),
    .i_ld_wb_addr      (i_ld_wb_addr),
    .i_ld_wb_data      (i_ld_wb_data),
    .o_ld_wb_ready     (o_ld_wb_ready),
    .o_rf_write_en     (o_rf_write_en),
    .o_rf_write_add    (o_rf_write_add),
    .o_rf_write_data   (o_rf_write_data),
    .o_pending         (o_pending),
    .o_wb_err          (o_wb_err)
  );

  // Advance one full cycle, then settle just after the falling edge.
  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_issue_valid = 1'b0; i_issue_inst = '0; i_issue_uses_rs2 = 1'b0;
    i_issue_writes_rd = 1'b0; i_flush = 1'b0;
    i_alu_wb_valid = 1'b0; i_alu_wb_addr = '0; i_alu_wb_data = '0;
    i_ld_wb_valid = 1'b0; i_ld_wb_addr = '0; i_ld_wb_data = '0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    idle_inputs();
    i_reset = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
  endtask

  task automatic issue(input logic [15:0] inst, input logic uses_rs2, input logic writes_rd);
    i_issue_valid = 1'b1; i_issue_inst = inst;
    i_issue_uses_rs2 = uses_rs2; i_issue_writes_rd = writes_rd;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_reset = 1'b0;
    @(negedge i_clk); #1;
    n_vec++; if (o_pending !== 16'h0000) begin n_err++; $display("FAIL reset_pending got %h exp 0000", o_pending); end
    n_vec++; if (o_rf_write_en !== 1'b0) begin n_err++; $display("FAIL reset_wen got %b exp 0", o_rf_write_en); end
    n_vec++; if ({o_rf_write_add, o_rf_write_data} !== 20'h0) begin n_err++; $display("FAIL reset_add_data got %h/%h exp 0/0000", o_rf_write_add, o_rf_write_data); end
    n_vec++; if (o_wb_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b exp 0", o_wb_err); end
    n_vec++; if (o_issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", o_issue_ready); end
    i_reset = 1'b1;
  endtask

  task automatic test_raw_commit();
    @(negedge i_clk);
    issue(16'h0123, 1'b1, 1'b1);
    #1;
    n_vec++; if (o_issue_ready !== 1'b1) begin n_err++; $display("FAIL raw_first_ready got %b exp 1", o_issue_ready); end
    step();
    issue(16'h0340, 1'b0, 1'b0);
    i_alu_wb_valid = 1'b1; i_alu_wb_addr = 4'd3; i_alu_wb_data = 16'hBEEF;
    #1;
    n_vec++; if (o_pending !== 16'h0008) begin n_err++; $display("FAIL raw_pending_set got %h exp 0008", o_pending); end
    n_vec++; if (o_issue_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall got %b exp 0", o_issue_ready); end
    n_vec++; if ({o_alu_wb_ready, o_ld_wb_ready} !== 2'b10) begin n_err++; $display("FAIL raw_wb_ready got %b exp 10", {o_alu_wb_ready, o_ld_wb_ready}); end
    step();
    i_alu_wb_valid = 1'b0;
    #1;
    n_vec++; if ({o_rf_write_en, o_rf_write_add, o_rf_write_data} !== {1'b1, 4'd3, 16'hBEEF}) begin n_err++; $display("FAIL raw_commit got %b/%h/%h exp 1/3/beef", o_rf_write_en, o_rf_write_add, o_rf_write_data); end
    n_vec++; if (o_issue_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall_during_commit got %b exp 0", o_issue_ready); end
    step();
    n_vec++; if (o_pending !== 16'h0000) begin n_err++; $display("FAIL raw_pending_clr got %h exp 0000", o_pending); end
    n_vec++; if ({o_rf_write_en, o_rf_write_add, o_rf_write_data} !== {1'b0, 4'd3, 16'hBEEF}) begin n_err++; $display("FAIL raw_commit_hold got %b/%h/%h exp 0/3/beef", o_rf_write_en, o_rf_write_add, o_rf_write_data); end
    n_vec++; if (o_issue_ready !== 1'b1) begin n_err++; $display("FAIL raw_release got %b exp 1", o_issue_ready); end
    n_vec++; if (o_wb_err !== 1'b0) begin n_err++; $display("FAIL raw_no_err got %b exp 0", o_wb_err); end
    step();
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy [4];
    logic [3:0]  exp_add [4];
    logic [15:0] exp_dat [4];
    exp_rdy = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_add = '{4'd1, 4'd2, 4'd1, 4'd2};
    exp_dat = '{16'h1111, 16'h2222, 16'h1111, 16'h2222};
    do_reset();
    i_alu_wb_valid = 1'b1; i_alu_wb_addr = 4'd1; i_alu_wb_data = 16'h1111;
    i_ld_wb_valid  = 1'b1; i_ld_wb_addr  = 4'd2; i_ld_wb_data  = 16'h2222;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_vec++; if ({o_alu_wb_ready, o_ld_wb_ready} !== exp_rdy[k]) begin n_err++; $display("FAIL rr_grant_%0d got %b exp %b", k, {o_alu_wb_ready, o_ld_wb_ready}, exp_rdy[k]); end
      if (k > 0) begin
        n_vec++; if ({o_rf_write_en, o_rf_write_add, o_rf_write_data} !== {1'b1, exp_add[k-1], exp_dat[k-1]}) begin n_err++; $display("FAIL rr_commit_%0d got %b/%h/%h exp 1/%h/%h", k, o_rf_write_en, o_rf_write_add, o_rf_write_data, exp_add[k-1], exp_dat[k-1]); end
      end
      step();
    end
    i_alu_wb_valid = 1'b0; i_ld_wb_valid = 1'b0;
    #1;
    n_vec++; if ({o_rf_write_en, o_rf_write_add, o_rf_write_data} !== {1'b1, 4'd2, 16'h2222}) begin n_err++; $display("FAIL rr_commit_last got %b/%h/%h exp 1/2/2222", o_rf_write_en, o_rf_write_add, o_rf_write_data); end
    n_vec++; if ({o_alu_wb_ready, o_ld_wb_ready} !== 2'b00) begin n_err++; $display("FAIL rr_no_valid_no_ready got %b exp 00", {o_alu_wb_ready, o_ld_wb_ready}); end
  endtask

  task automatic test_inflight_limit();
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      issue(16'(r), 1'b0, 1'b1);
      #1;
      n_vec++; if (o_issue_ready !== 1'b1) begin n_err++; $display("FAIL lim_issue_r%0d got %b exp 1", r, o_issue_ready); end
      step();
    end
    issue(16'h0005, 1'b0, 1'b1);
    #1;
    n_vec++; if (o_pending !== 16'h001E) begin n_err++; $display("FAIL lim_pending got %h exp 001e", o_pending); end
    n_vec++; if (o_issue_ready !== 1'b0) begin n_err++; $display("FAIL lim_fifth_stall got %b exp 0", o_issue_ready); end
    i_issue_writes_rd = 1'b0;
    #1;
    n_vec++; if (o_issue_ready !== 1'b1) begin n_err++; $display("FAIL lim_nonwriter_ok got %b exp 1", o_issue_ready); end
    i_issue_valid = 1'b0; i_issue_writes_rd = 1'b1;
    i_alu_wb_valid = 1'b1; i_alu_wb_addr = 4'd1; i_alu_wb_data = 16'h0A01;
    step();
    i_alu_wb_valid = 1'b0;
    i_issue_valid = 1'b1;
    #1;
    n_vec++; if (o_issue_ready !== 1'b0) begin n_err++; $display("FAIL lim_stall_in_commit got %b exp 0", o_issue_ready); end
    step();
    n_vec++; if (o_issue_ready !== 1'b1) begin n_err++; $display("FAIL lim_release got %b exp 1", o_issue_ready); end
    n_vec++; if (o_pending !== 16'h001C) begin n_err++; $display("FAIL lim_pending_after_clr got %h exp 001c", o_pending); end
    step();
    idle_inputs();
    #1;
    n_vec++; if (o_pending !== 16'h003C) begin n_err++; $display("FAIL lim_fifth_issued got %h exp 003c", o_pending); end
  endtask

  task automatic test_wb_error();
    do_reset();
    i_ld_wb_valid = 1'b1; i_ld_wb_addr = 4'd7; i_ld_wb_data = 16'h7777;
    #1;
    n_vec++; if (o_ld_wb_ready !== 1'b1) begin n_err++; $display("FAIL err_ld_ready got %b exp 1", o_ld_wb_ready); end
    step();
    i_ld_wb_valid = 1'b0;
    #1;
    n_vec++; if (o_wb_err !== 1'b1) begin n_err++; $display("FAIL err_set got %b exp 1", o_wb_err); end
    n_vec++; if ({o_rf_write_en, o_rf_write_add, o_rf_write_data} !== {1'b1, 4'd7, 16'h7777}) begin n_err++; $display("FAIL err_still_commits got %b/%h/%h exp 1/7/7777", o_rf_write_en, o_rf_write_add, o_rf_write_data); end
    step(); step(); step();
    n_vec++; if (o_wb_err !== 1'b1) begin n_err++; $display("FAIL err_sticky got %b exp 1", o_wb_err); end
    n_vec++; if (o_pending !== 16'h0000) begin n_err++; $display("FAIL err_pending got %h exp 0000", o_pending); end
  endtask

  task automatic test_flush();
    issue(16'h0129, 1'b1, 1'b1);
    i_flush = 1'b1;
    #1;
    n_vec++; if (o_issue_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got %b exp 0", o_issue_ready); end
    step();
    n_vec++; if (o_pending !== 16'h0000) begin n_err++; $display("FAIL flush_no_set got %h exp 0000", o_pending); end
    i_flush = 1'b0;
    #1;
    n_vec++; if (o_issue_ready !== 1'b1) begin n_err++; $display("FAIL flush_released got %b exp 1", o_issue_ready); end
    idle_inputs();
  endtask

  task automatic test_async_reset_mid_commit();
    issue(16'h0003, 1'b0, 1'b1);
    step();
    idle_inputs();
    i_alu_wb_valid = 1'b1; i_alu_wb_addr = 4'd3; i_alu_wb_data = 16'hCAFE;
    step();
    i_alu_wb_valid = 1'b0;
    #1;
    n_vec++; if ({o_rf_write_en, o_pending} !== {1'b1, 16'h0008}) begin n_err++; $display("FAIL arst_pre got %b/%h exp 1/0008", o_rf_write_en, o_pending); end
    i_reset = 1'b0;
    #1;
    n_vec++; if ({o_rf_write_en, o_pending} !== {1'b0, 16'h0000}) begin n_err++; $display("FAIL arst_immediate got %b/%h exp 0/0000", o_rf_write_en, o_pending); end
    n_vec++; if ({o_wb_err, o_rf_write_add, o_rf_write_data} !== 21'h0) begin n_err++; $display("FAIL arst_clear got %b/%h/%h exp 0/0/0000", o_wb_err, o_rf_write_add, o_rf_write_data); end
    #1;
    i_reset = 1'b1;
    i_alu_wb_valid = 1'b1; i_alu_wb_addr = 4'd4; i_alu_wb_data = 16'h4444;
    step();
    i_alu_wb_valid = 1'b0;
    #1;
    n_vec++; if (o_wb_err !== 1'b1) begin n_err++; $display("FAIL arst_stale_wb_err got %b exp 1", o_wb_err); end
  endtask

  initial begin
    test_reset();
    test_raw_commit();
    test_round_robin();
    test_inflight_limit();
    test_wb_error();
    test_flush();
    test_async_reset_mid_commit();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
